// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

    // Loader control states.
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        HDR  = 2'd1,
        LOAD = 2'd2,
        RUN  = 2'd3
    } state_t;

    // Position of the next accepted byte within a 3-byte instruction word.
    typedef enum logic [1:0] {
        PH_HI  = 2'd0,
        PH_MID = 2'd1,
        PH_LO  = 2'd2
    } phase_t;

    // Accepted header word counts lie in HDR_MIN..depth.
    localparam int unsigned HDR_MIN = 1;

    function automatic logic hdr_valid(input logic [7:0] n, input int unsigned depth);
        return (32'(n) >= HDR_MIN) && (32'(n) <= depth);
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: synchronous write, asynchronous read, no reset.
module imem_ram #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 7,
    parameter int unsigned WIDTH = 17
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader for the CPU instruction memory; holds the CPU
// in reset while a program is loaded and masks reads outside the loaded image.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = 128
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] imemaddr,
    output logic [16:0] imemrdata,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        cpu_reset,
    output logic        ld_error,
    output logic [7:0]  word_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_t      state_q, state_d;
    phase_t      phase_q;
    logic [7:0]  wptr_q;
    logic [7:0]  n_q;
    logic [7:0]  word_count_q;
    logic        hi_q;
    logic [7:0]  mid_q;
    logic        err_q;
    logic        restart_q;

    logic        start_load;
    logic        hdr_good;
    logic        hdr_bad;
    logic        byte0_err;
    logic        wr_en;
    logic        load_done;
    logic        in_range;
    logic [16:0] ram_rdata;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = imemaddr[0];

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        state_d    = state_q;
        start_load = 1'b0;
        hdr_good   = 1'b0;
        hdr_bad    = 1'b0;
        byte0_err  = 1'b0;
        wr_en      = 1'b0;
        load_done  = 1'b0;
        case (state_q)
            HOLD: begin
                if (ld_start || restart_q) begin
                    start_load = 1'b1;
                    state_d    = HDR;
                end
            end
            HDR: begin
                if (ld_valid) begin
                    if (hdr_valid(ld_data, DEPTH)) begin
                        hdr_good = 1'b1;
                        state_d  = LOAD;
                    end else begin
                        hdr_bad = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    case (phase_q)
                        PH_HI:   byte0_err = |ld_data[7:1];
                        PH_LO: begin
                            wr_en = 1'b1;
                            if (wptr_q + 8'd1 == n_q) begin
                                load_done = 1'b1;
                                state_d   = RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (ld_start) begin
                    state_d = HOLD;
                end
            end
            default: state_d = HOLD;
        endcase
    end

    // Pointer, byte assembler, header, counters and error flag.
    // A start seen in RUN is remembered so HOLD launches the reload on its own
    // after spending one cycle with cpu_reset asserted.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q      <= PH_HI;
            wptr_q       <= '0;
            n_q          <= '0;
            word_count_q <= '0;
            hi_q         <= 1'b0;
            mid_q        <= '0;
            err_q        <= 1'b0;
            restart_q    <= 1'b0;
        end else begin
            if (start_load) begin
                wptr_q    <= '0;
                phase_q   <= PH_HI;
                err_q     <= 1'b0;
                restart_q <= 1'b0;
            end
            if (state_q == RUN && ld_start) begin
                restart_q <= 1'b1;
            end
            if (hdr_good) begin
                n_q <= ld_data;
            end
            if (hdr_bad || byte0_err) begin
                err_q <= 1'b1;
            end
            if (state_q == LOAD && ld_valid) begin
                case (phase_q)
                    PH_HI: begin
                        hi_q    <= ld_data[0];
                        phase_q <= PH_MID;
                    end
                    PH_MID: begin
                        mid_q   <= ld_data;
                        phase_q <= PH_LO;
                    end
                    PH_LO: begin
                        wptr_q  <= wptr_q + 8'd1;
                        phase_q <= PH_HI;
                    end
                    default: phase_q <= PH_HI;
                endcase
            end
            if (load_done) begin
                word_count_q <= n_q;
            end
        end
    end

    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (17)
    ) u_ram (
        .clock (clock),
        .we    (wr_en),
        .waddr (wptr_q[AW-1:0]),
        .wdata ({hi_q, mid_q, ld_data}),
        .raddr (imemaddr[AW:1]),
        .rdata (ram_rdata)
    );

    // Comparing the full word index against the count also rejects any
    // nonzero upper address bits, so out-of-range addresses never alias.
    assign in_range   = (state_q == RUN) && (imemaddr[15:1] < 15'(word_count_q));
    assign imemrdata  = in_range ? ram_rdata : '0;

    assign ld_ready   = (state_q == HDR) || (state_q == LOAD);
    assign cpu_reset  = (state_q != RUN);
    assign ld_error   = err_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader against a byte-stream program model.
module tb_imem_loader;

    localparam int unsigned DEPTH = 128;

    typedef logic [7:0] bq_t[$];

    logic        clock;
    logic        reset;
    logic [15:0] imemaddr;
    logic [16:0] imemrdata;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        cpu_reset;
    logic        ld_error;
    logic [7:0]  word_count;

    int n_checks;
    int n_fail;

    // Reference model of what the CPU should observe.
    logic [16:0] mdl_mem [DEPTH];
    logic [7:0]  mdl_wc;
    bit          mdl_run;
    bit          mdl_err;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .imemaddr   (imemaddr),
        .imemrdata  (imemrdata),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .cpu_reset  (cpu_reset),
        .ld_error   (ld_error),
        .word_count (word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void model_reset();
        mdl_wc  = 8'd0;
        mdl_run = 1'b0;
        mdl_err = 1'b0;
    endfunction

    // Interpret a complete load stream: header N, then N big-endian triples.
    function automatic void model_load(input bq_t b);
        int unsigned n;
        n = b[0];
        mdl_err = 1'b0;
        mdl_run = 1'b0;
        if (n == 0 || n > DEPTH) begin
            mdl_err = 1'b1;
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            logic [7:0] b0;
            b0 = b[1 + 3*i];
            if (b0[7:1] != 7'd0) mdl_err = 1'b1;
            mdl_mem[i] = {b0[0], b[2 + 3*i], b[3 + 3*i]};
        end
        mdl_wc  = 8'(n);
        mdl_run = 1'b1;
    endfunction

    function automatic logic [16:0] model_read(input logic [15:0] a);
        int unsigned idx;
        idx = a / 2;
        if (mdl_run && idx < mdl_wc) return mdl_mem[idx];
        return 17'd0;
    endfunction

    task automatic do_reset();
        reset    = 1'b1;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 8'd0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        @(posedge clock);
        #1;
        ld_start = 1'b0;
        mdl_run = 1'b0;
    endtask

    // Drive a byte stream, with min..max idle cycles before each byte;
    // noise asserts ld_start randomly during idle cycles.
    task automatic send_bytes(input bq_t b, input int unsigned min_stall,
                              input int unsigned max_stall, input bit noise);
        foreach (b[i]) begin
            int unsigned w;
            int unsigned k;
            k = $urandom_range(max_stall, min_stall);
            for (int unsigned s = 0; s < k; s++) begin
                ld_valid = 1'b0;
                ld_data  = 8'($urandom);
                ld_start = noise ? 1'($urandom_range(1, 0)) : 1'b0;
                @(posedge clock);
                #1;
            end
            ld_start = 1'b0;
            ld_valid = 1'b1;
            ld_data  = b[i];
            w = 0;
            while (!ld_ready && w < 20) begin
                @(posedge clock);
                #1;
                w++;
            end
            n_checks++;
            if (ld_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL byte_accept: ld_ready=%b want 1 at byte %0d", ld_ready, i);
            end
            @(posedge clock);
            #1;
            ld_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        imemaddr = 16'h0000;
        #1;
        n_checks++;
        if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
        n_checks++;
        if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
        n_checks++;
        if (ld_error !== 1'b0) begin n_fail++; $display("FAIL reset_ld_error: got %b want 0", ld_error); end
        n_checks++;
        if (word_count !== 8'd0) begin n_fail++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
        n_checks++;
        if (imemrdata !== 17'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", imemrdata); end
    endtask

    task automatic test_basic();
        bq_t b;
        b = '{8'h02, 8'h01, 8'h23, 8'h45, 8'h00, 8'hAB, 8'hCD};
        pulse_start();
        send_bytes(b, 0, 0, 1'b0);
        model_load(b);
        n_checks++;
        if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL basic_cpu_reset: got %b want 0", cpu_reset); end
        n_checks++;
        if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ld_ready: got %b want 0", ld_ready); end
        n_checks++;
        if (ld_error !== 1'b0) begin n_fail++; $display("FAIL basic_ld_error: got %b want 0", ld_error); end
        n_checks++;
        if (word_count !== 8'd2) begin n_fail++; $display("FAIL basic_word_count: got %0d want 2", word_count); end
        imemaddr = 16'h0000; #1;
        n_checks++;
        if (imemrdata !== 17'h12345) begin n_fail++; $display("FAIL basic_rd0: got %h want 12345", imemrdata); end
        imemaddr = 16'h0002; #1;
        n_checks++;
        if (imemrdata !== 17'h0ABCD) begin n_fail++; $display("FAIL basic_rd2: got %h want 0abcd", imemrdata); end
        imemaddr = 16'h0004; #1;
        n_checks++;
        if (imemrdata !== 17'h00000) begin n_fail++; $display("FAIL basic_rd4: got %h want 0", imemrdata); end
    endtask

    task automatic test_bad_header();
        bq_t b;
        b = '{8'h00};
        pulse_start();
        send_bytes(b, 0, 0, 1'b0);
        model_load(b);
        imemaddr = 16'h0000; #1;
        n_checks++;
        if (ld_error !== mdl_err) begin n_fail++; $display("FAIL badhdr0_ld_error: got %b want %b", ld_error, mdl_err); end
        n_checks++;
        if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL badhdr0_cpu_reset: got %b want 1", cpu_reset); end
        n_checks++;
        if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL badhdr0_ld_ready: got %b want 0", ld_ready); end
        n_checks++;
        if (imemrdata !== model_read(imemaddr)) begin n_fail++; $display("FAIL badhdr0_rdata: got %h want %h", imemrdata, model_read(imemaddr)); end
        pulse_start();
        n_checks++;
        if (ld_error !== 1'b0) begin n_fail++; $display("FAIL badhdr_clear_error: got %b want 0", ld_error); end
        n_checks++;
        if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL badhdr_hdr_ready: got %b want 1", ld_ready); end
        b = '{8'(DEPTH + 1)};
        send_bytes(b, 0, 0, 1'b0);
        model_load(b);
        n_checks++;
        if (ld_error !== mdl_err) begin n_fail++; $display("FAIL badhdr_big_ld_error: got %b want %b", ld_error, mdl_err); end
        n_checks++;
        if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL badhdr_big_cpu_reset: got %b want 1", cpu_reset); end
        n_checks++;
        if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL badhdr_big_ld_ready: got %b want 0", ld_ready); end
    endtask

    task automatic test_stalls();
        bq_t b;
        b = '{8'h02, 8'h01, 8'h23, 8'h45, 8'h00, 8'hAB, 8'hCD};
        pulse_start();
        send_bytes(b, 1, 3, 1'b0);
        model_load(b);
        n_checks++;
        if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL stall_cpu_reset: got %b want 0", cpu_reset); end
        n_checks++;
        if (word_count !== 8'd2) begin n_fail++; $display("FAIL stall_word_count: got %0d want 2", word_count); end
        n_checks++;
        if (ld_error !== 1'b0) begin n_fail++; $display("FAIL stall_ld_error: got %b want 0", ld_error); end
        for (int a = 0; a < 12; a++) begin
            imemaddr = 16'(a); #1;
            n_checks++;
            if (imemrdata !== model_read(imemaddr))
                begin n_fail++; $display("FAIL stall_rd: addr %h got %h want %h", imemaddr, imemrdata, model_read(imemaddr)); end
        end
    endtask

    task automatic test_midload_reset();
        bq_t b;
        b = '{8'h02, 8'h01, 8'h23, 8'h45};
        pulse_start();
        send_bytes(b, 0, 1, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        n_checks++;
        if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL midrst_cpu_reset: got %b want 1", cpu_reset); end
        n_checks++;
        if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ld_ready: got %b want 0", ld_ready); end
        n_checks++;
        if (word_count !== 8'd0) begin n_fail++; $display("FAIL midrst_word_count: got %0d want 0", word_count); end
        for (int i = 0; i < int'(DEPTH); i++) begin
            imemaddr = 16'(2*i); #1;
            n_checks++;
            if (imemrdata !== 17'd0)
                begin n_fail++; $display("FAIL midrst_rd: addr %h got %h want 0", imemaddr, imemrdata); end
        end
    endtask

    task automatic test_reload();
        bq_t b;
        b = '{8'h02, 8'h01, 8'h23, 8'h45, 8'h00, 8'hAB, 8'hCD};
        pulse_start();
        send_bytes(b, 0, 0, 1'b0);
        model_load(b);
        n_checks++;
        if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL reload_pre_cpu_reset: got %b want 0", cpu_reset); end
        pulse_start();
        imemaddr = 16'h0000; #1;
        n_checks++;
        if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL reload_pulse_cpu_reset: got %b want 1", cpu_reset); end
        n_checks++;
        if (imemrdata !== model_read(imemaddr)) begin n_fail++; $display("FAIL reload_hold_rd: got %h want %h", imemrdata, model_read(imemaddr)); end
        b = '{8'h01, 8'h01, 8'hFF, 8'hFF};
        send_bytes(b, 0, 0, 1'b0);
        model_load(b);
        n_checks++;
        if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL reload_cpu_reset: got %b want 0", cpu_reset); end
        n_checks++;
        if (word_count !== 8'd1) begin n_fail++; $display("FAIL reload_word_count: got %0d want 1", word_count); end
        imemaddr = 16'h0000; #1;
        n_checks++;
        if (imemrdata !== 17'h1FFFF) begin n_fail++; $display("FAIL reload_rd0: got %h want 1ffff", imemrdata); end
        imemaddr = 16'h0002; #1;
        n_checks++;
        if (imemrdata !== 17'h0) begin n_fail++; $display("FAIL reload_rd2: got %h want 0", imemrdata); end
        imemaddr = 16'h0100; #1;
        n_checks++;
        if (imemrdata !== 17'h0) begin n_fail++; $display("FAIL reload_rd100: got %h want 0", imemrdata); end
        imemaddr = 16'h0001; #1;
        n_checks++;
        if (imemrdata !== 17'h1FFFF) begin n_fail++; $display("FAIL reload_rd1: got %h want 1ffff", imemrdata); end
    endtask

    task automatic test_byte0_error();
        bq_t b;
        b = '{8'h01, 8'h03, 8'h12, 8'h34};
        pulse_start();
        send_bytes(b, 0, 0, 1'b0);
        model_load(b);
        imemaddr = 16'h0000; #1;
        n_checks++;
        if (imemrdata !== 17'h11234) begin n_fail++; $display("FAIL b0err_rd0: got %h want 11234", imemrdata); end
        n_checks++;
        if (ld_error !== 1'b1) begin n_fail++; $display("FAIL b0err_ld_error: got %b want 1", ld_error); end
        n_checks++;
        if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL b0err_cpu_reset: got %b want 0", cpu_reset); end
        n_checks++;
        if (word_count !== 8'd1) begin n_fail++; $display("FAIL b0err_word_count: got %0d want 1", word_count); end
    endtask

    task automatic test_random_loads();
        for (int it = 0; it < 6; it++) begin
            bq_t b;
            int unsigned n;
            n = (it == 0) ? DEPTH : $urandom_range(12, 1);
            b = {};
            b.push_back(8'(n));
            for (int unsigned w = 0; w < n; w++) begin
                if ($urandom_range(3, 0) == 0) b.push_back(8'($urandom));
                else                           b.push_back({7'd0, 1'($urandom)});
                b.push_back(8'($urandom));
                b.push_back(8'($urandom));
            end
            pulse_start();
            send_bytes(b, 0, 2, 1'b1);
            model_load(b);
            n_checks++;
            if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL rand_cpu_reset: iter %0d got %b want 0", it, cpu_reset); end
            n_checks++;
            if (ld_error !== mdl_err) begin n_fail++; $display("FAIL rand_ld_error: iter %0d got %b want %b", it, ld_error, mdl_err); end
            n_checks++;
            if (word_count !== mdl_wc) begin n_fail++; $display("FAIL rand_word_count: iter %0d got %0d want %0d", it, word_count, mdl_wc); end
            for (int r = 0; r < 16; r++) begin
                if (r < 12) imemaddr = 16'($urandom_range(2*n + 3, 0));
                else        imemaddr = 16'($urandom);
                #1;
                n_checks++;
                if (imemrdata !== model_read(imemaddr))
                    begin n_fail++; $display("FAIL rand_rd: iter %0d addr %h got %h want %h", it, imemaddr, imemrdata, model_read(imemaddr)); end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        imemaddr = 16'h0000;
        test_reset();
        test_basic();
        test_bad_header();
        test_stalls();
        test_midload_reset();
        test_reload();
        test_byte0_error();
        test_random_loads();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 128: instruction memory size in 17-bit words, power of two, 2..128.
REQ-002 SHALL have port clock  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port imemaddr  input  16  CPU instruction byte address; word index = imemaddr[log2(DEPTH):1].
REQ-005 SHALL have port imemrdata  output  17  instruction word returned to the CPU.
REQ-006 SHALL have port ld_start  input  1  one-cycle request to begin a program load.
REQ-007 SHALL have port ld_valid  input  1  load byte valid.
REQ-008 SHALL have port ld_data  input  8  load byte.
REQ-009 SHALL have port ld_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port cpu_reset  output  1  reset driven to the pipelined CPU.
REQ-011 SHALL have port ld_error  output  1  sticky load-error flag.
REQ-012 SHALL have port word_count  output  8  number of words loaded by the last successful load.

Function
REQ-013 SHALL implement FSM states HOLD, HDR, LOAD and RUN.
REQ-014 HOLD SHALL drive cpu_reset=1 and ld_ready=0; on ld_start=1 it SHALL go to HDR, clear the write pointer and byte phase, and clear ld_error.
REQ-015 HDR SHALL drive ld_ready=1; the accepted byte (ld_valid & ld_ready) is N = word count.
REQ-016 In HDR, N=0 or N>DEPTH SHALL set ld_error and return to HOLD; otherwise it SHALL store N and go to LOAD.
REQ-017 LOAD SHALL drive ld_ready=1 and assemble each word from 3 accepted bytes: byte0[0]=bit16, byte1=bits15:8, byte2=bits7:0.
REQ-018 If byte0[7:1] is nonzero, ld_error SHALL be set; loading SHALL continue and use byte0[0] only.
REQ-019 On acceptance of byte2, the word SHALL be written to mem[wptr], wptr SHALL increment, and the word SHALL be readable the next cycle.
REQ-020 After word N is written, the FSM SHALL go to RUN, with word_count=N and cpu_reset=0 from the next cycle onward.
REQ-021 Cycles with ld_valid=0 SHALL hold the byte phase and pointer; there is no timeout.
REQ-022 ld_start in HDR or LOAD SHALL be ignored.
REQ-023 ld_start in RUN SHALL return the FSM to HOLD, reasserting cpu_reset the next cycle, and then start a load as in REQ-014.
REQ-024 RUN SHALL drive ld_ready=0.
REQ-025 imemrdata SHALL be combinational from imemaddr, and SHALL be mem[index] only when state=RUN, index<word_count and imemaddr[15:log2(DEPTH)+1]==0; otherwise it SHALL be 0.
REQ-026 imemaddr[0] SHALL be ignored.
REQ-027 The word index SHALL never wrap: out-of-range addresses SHALL read 0 and SHALL NOT alias.
REQ-028 cpu_reset and ld_ready SHALL be registered or decoded from the state register only, with no combinational path from ld_valid.

Reset
REQ-029 On reset the FSM SHALL enter HOLD; cpu_reset=1, ld_ready=0, ld_error=0, word_count=0, wptr=0, byte phase=0.
REQ-030 Memory contents SHALL NOT be reset; REQ-025 masking guarantees imemrdata=0 until a load completes.
REQ-031 Reset asserted during HDR or LOAD SHALL abort the load, apply REQ-029, and leave partial data unreadable.

Structure
REQ-032 The state enum, the header bounds (1..DEPTH) and the byte-phase constants SHALL live in a shared package, imem_pkg.
REQ-033 Storage SHALL be a sub-module imem_ram: DEPTH x 17 bits, synchronous write on the clock rising edge, asynchronous read.
REQ-034 The FSM, byte assembler and counters SHALL live in imem_loader.

Verification
REQ-035 Basic load: reset, ld_start, bytes 02, 01,23,45, 00,AB,CD -> RUN; cpu_reset=0; word_count=2; imemaddr 0 -> 0x12345, 2 -> 0x0ABCD, 4 -> 0.
REQ-036 Bad header: load with header 00 -> ld_error=1, HOLD, cpu_reset=1; repeat with header DEPTH+1 -> same result.
REQ-037 Stalls: basic load with ld_valid=0 inserted between every byte -> same result as REQ-035; no extra writes.
REQ-038 Mid-load reset: reset after 4 bytes of the basic load -> HOLD, word_count=0, imemrdata=0 at all addresses.
REQ-039 Reload and bounds: in RUN, ld_start and load 01, 01,FF,FF -> cpu_reset pulses high then low; word_count=1; addr 0 -> 0x1FFFF; addr 2 -> 0; addr 0x0100 -> 0; odd addr 1 -> 0x1FFFF.
REQ-040 Byte0 error: load with byte0=0x03 -> word bit16=1; ld_error=1; load still completes to RUN.
